// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: runs the FFT core's config handshake, then streams
// frame sets of NUM_CH channels (one NFFT-sample frame each, tlast on the
// final sample) out of the ring buffer into the FFT data port.
// A reconfig request during a frame set is remembered and serviced once the
// set has finished. A frame request arriving while a set cannot start is
// reported on frame_overrun.
module fft_frame_sequencer #(
   parameter int NUM_CH    = 4,
   parameter int NFFT_LOG2 = 10,
   parameter int DATA_W    = 32,
   parameter int CFG_W     = 16,
   parameter int CH_W      = 2
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic [CFG_W-1:0]     cfg_word,
   input  logic                 reconfig,
   input  logic                 frame_req,
   input  logic                 s_axis_config_tready,
   output logic                 s_axis_config_tvalid,
   output logic [CFG_W-1:0]     s_axis_config_tdata,
   output logic [CH_W-1:0]      buf_rd_ch,
   output logic [NFFT_LOG2-1:0] buf_rd_addr,
   input  logic [DATA_W-1:0]    buf_rd_data,
   input  logic                 s_axis_data_tready,
   output logic                 s_axis_data_tvalid,
   output logic [DATA_W-1:0]    s_axis_data_tdata,
   output logic                 s_axis_data_tlast,
   output logic                 config_done,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_overrun,
   output logic [15:0]          frames_sent
);

   localparam logic [NFFT_LOG2-1:0] ADDR_LAST = '1;
   localparam logic [CH_W-1:0]      CH_LAST   = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIG,
      ST_READY,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CFG_W-1:0]     cfg_tdata_q, cfg_tdata_d;
   logic                 config_done_q, config_done_d;
   logic                 pending_q, pending_d;
   logic                 overrun_q, overrun_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [NFFT_LOG2-1:0] addr_q, addr_d;
   logic [15:0]          frames_sent_q, frames_sent_d;
   logic                 enter_cfg;

   // Next-state logic: sequencing, channel/sample counters, reconfig bookkeeping.
   always_comb begin
      state_d       = state_q;
      cfg_tdata_d   = cfg_tdata_q;
      config_done_d = config_done_q;
      pending_d     = pending_q;
      ch_d          = ch_q;
      addr_d        = addr_q;
      frames_sent_d = frames_sent_q;
      enter_cfg     = 1'b0;
      // A frame request is honoured only in READY when no reconfig takes precedence.
      overrun_d     = frame_req & ~((state_q == ST_READY) & ~reconfig & ~pending_q);

      case (state_q)
         ST_IDLE: begin
            enter_cfg = 1'b1;
         end
         ST_CONFIG: begin
            if (reconfig) begin
               pending_d = 1'b1;
            end
            if (s_axis_config_tready) begin
               state_d       = ST_READY;
               config_done_d = 1'b1;
            end
         end
         ST_READY: begin
            if (reconfig || pending_q) begin
               enter_cfg = 1'b1;
            end else if (frame_req) begin
               state_d = ST_SEND;
               ch_d    = '0;
               addr_d  = '0;
            end
         end
         ST_SEND: begin
            if (reconfig) begin
               pending_d = 1'b1;
            end
            if (s_axis_data_tready) begin
               if (addr_q == ADDR_LAST) begin
                  if (ch_q == CH_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     ch_d   = ch_q + CH_W'(1);
                     addr_d = '0;
                  end
               end else begin
                  addr_d = addr_q + NFFT_LOG2'(1);
               end
            end
         end
         ST_DONE: begin
            frames_sent_d = frames_sent_q + 16'd1;
            if (reconfig || pending_q) begin
               enter_cfg = 1'b1;
            end else begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enter_cfg) begin
         state_d       = ST_CONFIG;
         cfg_tdata_d   = cfg_word;
         config_done_d = 1'b0;
         pending_d     = 1'b0;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q       <= ST_IDLE;
         cfg_tdata_q   <= '0;
         config_done_q <= 1'b0;
         pending_q     <= 1'b0;
         overrun_q     <= 1'b0;
         ch_q          <= '0;
         addr_q        <= '0;
         frames_sent_q <= '0;
      end else begin
         state_q       <= state_d;
         cfg_tdata_q   <= cfg_tdata_d;
         config_done_q <= config_done_d;
         pending_q     <= pending_d;
         overrun_q     <= overrun_d;
         ch_q          <= ch_d;
         addr_q        <= addr_d;
         frames_sent_q <= frames_sent_d;
      end
   end

   assign s_axis_config_tvalid = (state_q == ST_CONFIG);
   assign s_axis_config_tdata  = cfg_tdata_q;
   assign buf_rd_ch            = ch_q;
   assign buf_rd_addr          = addr_q;
   assign s_axis_data_tvalid   = (state_q == ST_SEND);
   assign s_axis_data_tdata    = (state_q == ST_SEND) ? buf_rd_data : '0;
   assign s_axis_data_tlast    = (state_q == ST_SEND) && (addr_q == ADDR_LAST);
   assign config_done          = config_done_q;
   assign busy                 = (state_q == ST_CONFIG) || (state_q == ST_SEND) || (state_q == ST_DONE);
   assign frame_done           = (state_q == ST_DONE);
   assign frame_overrun        = overrun_q;
   assign frames_sent          = frames_sent_q;

endmodule
